// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic operation requests (ADD/LW/SW) into 32-bit
// instruction words, buffers them in a small FIFO and drains them one word per
// cycle onto an instruction-memory write port at consecutive word addresses.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready request handshake (accepted when both high at an edge)
//   req_op          00=ADD, 01=LW, 10=SW, 11=illegal (accepted, dropped, flagged)
//   req_rs/rt/rd    register fields; req_imm is the LW/SW offset
//   drain_en        permits FIFO pops to memory
//   clr             synchronous clear, overrides push and pop
//   imem_we/addr/wdata  registered write port, one-cycle strobe per pop
//   fifo_count      FIFO occupancy
//   words_written   writes since reset or clr (wraps at 2^16)
//   illegal_err     sticky flag, set by an accepted illegal op
module instr_encoder #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [4:0]                 req_rs,
  input  logic [4:0]                 req_rt,
  input  logic [4:0]                 req_rd,
  input  logic [15:0]                req_imm,
  input  logic                       drain_en,
  input  logic                       clr,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                words_written,
  output logic                       illegal_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpLw  = 2'b01;
  localparam logic [1:0] OpSw  = 2'b10;

  logic [31:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_idx_q, wr_idx_d;
  logic [PtrW-1:0]   rd_idx_q, rd_idx_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [15:0]       words_q, words_d;
  logic              illegal_q, illegal_d;

  logic [31:0] enc_word;
  logic        full, empty, accept, legal, push, pop;

  // Instruction encoding: [31:26] opcode, [25:21] rs, [20:16] rt, low half per op.
  always_comb begin
    enc_word = '0;
    case (req_op)
      OpAdd:   enc_word = {6'b000001, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      OpLw:    enc_word = {6'b000100, req_rs, req_rt, req_imm};
      OpSw:    enc_word = {6'b000010, req_rs, req_rt, req_imm};
      default: enc_word = '0;
    endcase
  end

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_ready = !full && !clr;
  assign accept    = req_valid && req_ready;
  assign legal     = (req_op != 2'b11);
  assign push      = accept && legal;
  // clr wins over a pop on the same edge.
  assign pop       = drain_en && !empty && !clr;

  always_comb begin
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    words_d   = words_q;
    illegal_d = illegal_q;

    if (clr) begin
      wr_idx_d  = '0;
      rd_idx_d  = '0;
      count_d   = '0;
      ptr_d     = BASE_ADDR;
      words_d   = '0;
      illegal_d = 1'b0;
    end else begin
      if (push) begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
      if (pop) begin
        rd_idx_d = rd_idx_q + 1'b1;
        we_d     = 1'b1;
        addr_d   = ptr_q;
        wdata_d  = mem_q[rd_idx_q];
        // Word-sized step, wrapping modulo 2^ADDR_W.
        ptr_d    = ptr_q + ADDR_W'(4);
        words_d  = words_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (accept && !legal) begin
        illegal_d = 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx_q] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      count_q   <= '0;
      ptr_q     <= BASE_ADDR;
      addr_q    <= BASE_ADDR;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      words_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      words_q   <= words_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign fifo_count    = count_q;
  assign words_written = words_q;
  assign illegal_err   = illegal_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the instruction decode/control unit: converts symbolic operation requests into 32-bit instruction words and writes them sequentially into instruction memory.
- Requests enter via a valid/ready handshake and are buffered in a FIFO.
- Words drain one per cycle onto an instruction-memory write port.
- Used by the test/loader path to build programs for the datapath.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 8, width of the instruction-memory byte address.
- BASE_ADDR, 0, first write address after reset or clr.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request.
- req_op  in  2  00=ADD, 01=LW, 10=SW, 11=illegal.
- req_rs  in  5  source register.
- req_rt  in  5  second source register, or load/store data register.
- req_rd  in  5  destination register (ADD only).
- req_imm  in  16  offset (LW/SW only).
- drain_en  in  1  permits FIFO pops to memory.
- clr  in  1  synchronous clear.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction.
- fifo_count  out  log2(DEPTH)+1  occupancy.
- words_written  out  16  total writes since reset or clr.
- illegal_err  out  1  sticky illegal-op flag.

Behaviour:
- Encoding fields: [31:26] opcode, [25:21] rs, [20:16] rt.
  - ADD: opcode 000001, [15:11] rd, [10:6] 0, [5:0] funct 100000.
  - LW: opcode 000100, [15:0] imm.
  - SW: opcode 000010, [15:0] imm.
  - req_rd is ignored for LW/SW; req_imm is ignored for ADD.
- Accept rule: a request is accepted on an edge where req_valid && req_ready.
  - req_ready = !full && !clr (combinational).
  - A legal accepted op is pushed into the FIFO at that edge.
  - An illegal op (11) is accepted but not pushed, and sets illegal_err.
- Pop rule: a pop occurs on an edge where drain_en is high and the FIFO is non-empty. It registers:
  - imem_we=1
  - imem_wdata = head word
  - imem_addr = current write pointer
  - It then advances the pointer by 4 and increments words_written.
- With no pop on an edge, imem_we=0 on the next cycle; imem_addr and imem_wdata hold their values.
- Latency: a request accepted at edge E0 can appear on imem_* at the earliest in the cycle after E1 (2 edges).
- Ordering: words are written in strict acceptance order.
- Push and pop on the same edge:
  - Both are allowed when the FIFO is non-empty and not full; fifo_count is unchanged.
  - When full, req_ready=0, so a push cannot coincide with the full state.
  - When empty, there is no pass-through: the pushed word pops on a later edge.
- Address wrap: the pointer wraps modulo 2^ADDR_W with no error.
- words_written wraps at 2^16.
- clr has priority over push and pop on the same edge. At that edge:
  - FIFO emptied.
  - Pointer = BASE_ADDR.
  - words_written = 0.
  - illegal_err = 0.
  - imem_we = 0.
  - Requests are not accepted while clr is high.
- Reset (rst_n low, at any time including mid-drain) forces immediately:
  - FIFO empty, fifo_count=0.
  - req_ready reflects empty, i.e. 1 once clr is low.
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - words_written=0, illegal_err=0.
  - Any in-flight write is discarded.
- No state machine beyond FIFO pointers.
  - Write-port state: IDLE (imem_we=0) and WRITE (imem_we=1, lasting exactly one cycle per pop).
  - Back-to-back pops give continuous WRITE cycles.

Test Plan:
- Encode: drain_en=1; ADD rs=1 rt=2 rd=3; LW rs=4 rt=5 imm=0x0010; SW rs=4 rt=6 imm=0xFFFC.
  - Expect writes 0x04221820 @0x00, 0x10850010 @0x04, 0x0886FFFC @0x08.
  - Expect words_written=3.
- Full/backpressure: drain_en=0, push 4 ADDs.
  - Expect fifo_count=4 and req_ready=0; a 5th request is held, not lost.
  - Then set drain_en=1: 5 writes in order at 0x00–0x10, one per cycle.
- Illegal op: req_op=11 between two legal ops.
  - Expect illegal_err=1 (sticky) and only 2 writes, at 0x00 and 0x04.
- Simultaneous push/pop at fifo_count=2 with drain_en=1.
  - Expect fifo_count stays 2 and output order preserved.
- Wrap: ADDR_W=4, 5 writes.
  - Expect addresses 0x0, 0x4, 0x8, 0xC, 0x0.
- clr/reset mid-drain: 3 words queued; clr for one cycle while popping.
  - Expect no imem_we on the following cycle, fifo_count=0, and the next write at BASE_ADDR.
  - Repeat with rst_n pulsed low asynchronously: outputs clear immediately.
